// File: rtl/time_counter_24.sv
// 24-hour binary time-of-day counter with 1 Hz prescaler, manual set modes and a
// one-cycle day rollover pulse. Optional alarm comparator enabled by defining ALARM_EN.
module time_counter_24 #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] mode,
    output logic       sec_tick,
    output logic       day_pulse,
    output logic       alarm
);

    localparam int            PW        = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_e;

    mode_e         r_mode;
    mode_e         w_mode_nxt;
    logic [PW-1:0] r_presc;
    logic [4:0]    r_hour;
    logic [5:0]    r_minute;
    logic [5:0]    r_second;
    logic          r_sec_tick;
    logic          r_day_pulse;

    logic w_run;
    logic w_tick;
    logic w_inc;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    assign w_run       = (r_mode == MODE_RUN);
    assign w_tick      = w_run && (r_presc == PRESC_MAX);
    // mode_btn has priority: a coincident inc_btn is dropped
    assign w_inc       = inc_btn && !mode_btn;
    assign w_sec_wrap  = (r_second == 6'd59);
    assign w_min_wrap  = (r_minute == 6'd59);
    assign w_hour_wrap = (r_hour == 5'd23);

    // NOTE: async reset is in the sensitivity list so it acts without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // NOTE: default assigned first so every path drives w_mode_nxt and no latch is inferred.
    always_comb begin
        w_mode_nxt = r_mode;
        if (mode_btn) begin
            case (r_mode)
                MODE_RUN:   w_mode_nxt = MODE_SET_H;
                MODE_SET_H: w_mode_nxt = MODE_SET_M;
                MODE_SET_M: w_mode_nxt = MODE_SET_S;
                MODE_SET_S: w_mode_nxt = MODE_RUN;
                default:    w_mode_nxt = MODE_RUN;
            endcase
        end
    end

    // Held at zero outside RUN so the first second after setting is a full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (!w_run || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hour   <= '0;
            r_minute <= '0;
            r_second <= '0;
        end else begin
            case (r_mode)
                MODE_RUN: begin
                    if (w_tick) begin
                        r_second <= w_sec_wrap ? 6'd0 : r_second + 6'd1;
                        if (w_sec_wrap) begin
                            r_minute <= w_min_wrap ? 6'd0 : r_minute + 6'd1;
                            if (w_min_wrap) begin
                                r_hour <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
                            end
                        end
                    end
                end
                MODE_SET_H: if (w_inc) r_hour   <= w_hour_wrap ? 5'd0 : r_hour + 5'd1;
                MODE_SET_M: if (w_inc) r_minute <= w_min_wrap  ? 6'd0 : r_minute + 6'd1;
                MODE_SET_S: if (w_inc) r_second <= w_sec_wrap  ? 6'd0 : r_second + 6'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_tick  <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_sec_tick  <= w_tick;
            r_day_pulse <= w_tick && w_sec_wrap && w_min_wrap && w_hour_wrap;
        end
    end

`ifdef ALARM_EN
    logic r_alarm;
    logic w_alarm_match;
    logic w_alarm_set;
    logic w_alarm_clr;

    // Fields are always in range, so out-of-range alarm inputs simply never compare equal
    assign w_alarm_match = (r_hour == alarm_hour) && (r_minute == alarm_minute);
    assign w_alarm_set   = r_sec_tick && w_run && (r_second == 6'd0) && w_alarm_match;
    assign w_alarm_clr   = inc_btn || (w_run && mode_btn) || (w_tick && w_sec_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_clr) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_set) begin
            r_alarm <= 1'b1;
        end
    end

    assign alarm = r_alarm;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{alarm_hour, alarm_minute};
    assign alarm          = 1'b0;
`endif

    assign hour      = r_hour;
    assign minute    = r_minute;
    assign second    = r_second;
    assign mode      = r_mode;
    assign sec_tick  = r_sec_tick;
    assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_time_counter_24.sv
// Scoreboard bench for time_counter_24 (CLK_DIV=4): stimulus queues expected second ticks,
// a negedge monitor pops and compares them; direct checks cover reset, setting and alarm.
module tb_time_counter_24;

    localparam int CLK_DIV = 4;
`ifdef ALARM_EN
    localparam logic ALM = 1'b1;
`else
    localparam logic ALM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic       sec_tick;
    logic       day_pulse;
    logic       alarm;

    time_counter_24 #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_btn     (mode_btn),
        .inc_btn      (inc_btn),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .mode         (mode),
        .sec_tick     (sec_tick),
        .day_pulse    (day_pulse),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_tick(input int c, input int h, input int m, input int s, input logic dp);
        exp_t e;
        e.cyc = c;
        e.h   = 5'(h);
        e.m   = 6'(m);
        e.s   = 6'(s);
        e.dp  = dp;
        sb.push_back(e);
    endtask

    // Called at a negedge; holds the buttons for exactly one rising edge
    task automatic press(input logic mb, input logic ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    // Monitor: every sec_tick must match the head of the scoreboard in cycle and value
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("tick_missing", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sec_tick) begin
                if (sb.size() == 0) begin
                    check("tick_unexpected", 32'(sec_tick), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tick_cycle",  cyc,       e.cyc);
                    check("tick_hour",   hour,      e.h);
                    check("tick_minute", minute,    e.m);
                    check("tick_second", second,    e.s);
                    check("tick_day",    day_pulse, e.dp);
                end
            end else if (day_pulse) begin
                check("day_pulse_stray", 32'(day_pulse), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst          = 1'b1;
        mode_btn     = 1'b0;
        inc_btn      = 1'b0;
        alarm_hour   = 5'd0;
        alarm_minute = 6'd60;
        repeat (2) @(negedge clk);
        check("rst_hour",      hour,      0);
        check("rst_minute",    minute,    0);
        check("rst_second",    second,    0);
        check("rst_mode",      mode,      0);
        check("rst_sec_tick",  sec_tick,  0);
        check("rst_day_pulse", day_pulse, 0);
        check("rst_alarm",     alarm,     0);

        // One minute of free running: tick every 4th cycle, 00:00:01 .. 00:01:00
        rst = 1'b0;
        c   = cyc;
        for (int i = 1; i <= 60; i++) push_tick(c + 4 * i, 0, i / 60, i % 60, 1'b0);
        repeat (240) @(negedge clk);
        check("t1_minute",    minute, 1);
        check("t1_second",    second, 0);
        check("t1_alarm_oor", alarm,  0);

        // Set 23:59:59 then roll over to midnight
        press(1'b1, 1'b0);
        check("t2_mode_set_h", mode, 1);
        repeat (23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("t2_mode_set_m", mode, 2);
        repeat (58) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("t2_mode_set_s", mode, 3);
        repeat (59) press(1'b0, 1'b1);
        check("t2_set_hour",   hour,   23);
        check("t2_set_minute", minute, 59);
        check("t2_set_second", second, 59);
        c = cyc;
        push_tick(c + 5, 0, 0, 0, 1'b1);
        press(1'b1, 1'b0);
        check("t2_mode_run", mode, 0);
        check("t2_frozen_second", second, 59);
        repeat (5) @(negedge clk);
        check("t2_day_pulse_one_cycle", day_pulse, 0);
        check("t2_alarm_oor", alarm, 0);

        // Field wrap without carry while setting
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t3_mode_set_m", mode, 2);
        repeat (61) press(1'b0, 1'b1);
        check("t3_minute", minute, 1);
        check("t3_hour",   hour,   0);
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        check("t3_second_59", second, 59);
        press(1'b0, 1'b1);
        check("t3_second_wrap", second, 0);
        check("t3_minute_kept", minute, 1);

        // mode_btn beats a coincident inc_btn
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t4_mode_set_h", mode, 1);
        repeat (5) press(1'b0, 1'b1);
        check("t4_hour_5", hour, 5);
        press(1'b1, 1'b1);
        check("t4_mode_set_m", mode, 2);
        check("t4_hour_kept",  hour, 5);

        // Asynchronous reset in SET_M, then in RUN with prescaler at 2
        rst = 1'b1;
        #1;
        check("t5_rst_hour",   hour,   0);
        check("t5_rst_minute", minute, 0);
        check("t5_rst_mode",   mode,   0);
        @(negedge clk);
        rst = 1'b0;
        c   = cyc;
        push_tick(c + 4, 0, 0, 1, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_run_rst_second", second,   0);
        check("t5_run_rst_tick",   sec_tick, 0);
        @(negedge clk);

        // Alarm at 00:01, ack with inc_btn in RUN; re-arm at 00:02, cleared by minute change
        alarm_minute = 6'd1;
        rst = 1'b0;
        c   = cyc;
        for (int i = 1; i <= 180; i++) push_tick(c + 4 * i, 0, i / 60, i % 60, 1'b0);
        repeat (240) @(negedge clk);
        check("t6_alarm_not_yet", alarm, 0);
        @(negedge clk);
        check("t6_alarm_set", alarm, 32'(ALM));
        press(1'b0, 1'b1);
        check("t6_alarm_ack", alarm, 0);
        alarm_minute = 6'd2;
        repeat (238) @(negedge clk);
        @(negedge clk);
        check("t6_alarm_set2", alarm, 32'(ALM));
        repeat (239) @(negedge clk);
        check("t6_alarm_minute_clear", alarm, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
